sample_stream_checker: RTL and testbench

//  Synthesisable, multi-channel golden-sample checker for decoder sample streams (Huffman, requantised, stereo).

---
 rtl/sample_chk_pkg.sv | 21 ++
 rtl/sample_ref_fifo.sv | 63 ++++++
 rtl/sample_stream_checker.sv | 162 ++++++++++++++++
 tb/tb_sample_stream_checker.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_chk_pkg.sv
// Shared definitions for the golden-sample stream checker.
//   chk_state_t     : checker FSM states (run, paused on mismatch threshold, framing error)
//   MP3_GRANULE_LEN : samples per channel per MP3 granule
//   CNT_W           : width of all mismatch / position counters
//   sat_inc()       : increment that sticks at all-ones
package sample_chk_pkg;

  localparam int unsigned MP3_GRANULE_LEN = 576;
  localparam int unsigned CNT_W           = 16;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_ERROR  = 2'd2
  } chk_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sample_ref_fifo.sv
// Synchronous reference-sample FIFO.
//   CLK_I, RESETN_I : clock, async active-low reset (empties the FIFO)
//   push, push_data : write request / data, ignored when full
//   pop             : read request, ignored when empty
//   pop_data        : head entry (valid while !empty)
//   full, empty     : occupancy flags
module sample_ref_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              CLK_I,
  input  logic              RESETN_I,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       level;
  logic              do_push;
  logic              do_pop;

  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge CLK_I) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sample_stream_checker.sv
// Multi-channel golden-sample checker for decoder sample streams.
// Reference samples are buffered in a FIFO; each accepted DUT sample pops one
// reference and is compared against it with a +/-TOLERANCE window.
//   CLK_I, RESETN_I      : clock, async active-low reset
//   REF_VALID_I/DATA_I   : reference stream in; REF_READY_O = FIFO not full
//   DUT_VALID_I/CH_I/DATA_I/LAST_I : DUT sample in; DUT_READY_O when running and a reference is buffered
//   PAUSE_ACK_I          : releases a threshold pause and clears the running count
//   MISMATCH_O, DIFF_O   : registered compare result (pulse) and signed dut-ref
//   MISMATCH_CNT_O       : running saturating mismatch count
//   GRANULE_DONE_O/CH_O/MM_O : end-of-granule pulse, its channel and its mismatch total
//   PAUSE_REQ_O          : paused on mismatch threshold
//   OVERRUN_O            : sticky framing error (LAST misplaced)
module sample_stream_checker
  import sample_chk_pkg::*;
#(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned GRANULE_LEN  = MP3_GRANULE_LEN,
  parameter int unsigned TOLERANCE    = 1,
  parameter int unsigned PAUSE_THRESH = 4,
  parameter int unsigned REF_DEPTH    = 8,
  parameter int unsigned CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     CLK_I,
  input  logic                     RESETN_I,
  input  logic                     REF_VALID_I,
  input  logic [DATA_W-1:0]        REF_DATA_I,
  output logic                     REF_READY_O,
  input  logic                     DUT_VALID_I,
  input  logic [CH_W-1:0]          DUT_CH_I,
  input  logic [DATA_W-1:0]        DUT_DATA_I,
  input  logic                     DUT_LAST_I,
  output logic                     DUT_READY_O,
  input  logic                     PAUSE_ACK_I,
  output logic                     MISMATCH_O,
  output logic signed [DATA_W:0]   DIFF_O,
  output logic [CNT_W-1:0]         MISMATCH_CNT_O,
  output logic                     GRANULE_DONE_O,
  output logic [CH_W-1:0]          GRANULE_CH_O,
  output logic [CNT_W-1:0]         GRANULE_MM_O,
  output logic                     PAUSE_REQ_O,
  output logic                     OVERRUN_O
);

  localparam int unsigned        NCH      = 2 ** CH_W;
  localparam logic [CNT_W-1:0]   LAST_POS = CNT_W'(GRANULE_LEN - 1);
  localparam logic [CNT_W-1:0]   THRESH   = CNT_W'(PAUSE_THRESH);
  localparam logic signed [DATA_W:0] TOL  = (DATA_W+1)'(TOLERANCE);

  chk_state_t state_q;
  chk_state_t state_d;

  logic [DATA_W-1:0]       ref_data;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    dut_acc;
  logic signed [DATA_W:0]  diff;
  logic                    mm;
  logic [CNT_W-1:0]        mm_cnt_next;
  logic [CNT_W-1:0]        gmm_next;
  logic                    at_end;
  logic                    framing_err;

  logic [CNT_W-1:0] pos_q [NCH];
  logic [CNT_W-1:0] gmm_q [NCH];

  sample_ref_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (REF_DEPTH)
  ) u_ref_fifo (
    .CLK_I     (CLK_I),
    .RESETN_I  (RESETN_I),
    .push      (REF_VALID_I),
    .push_data (REF_DATA_I),
    .pop       (dut_acc),
    .pop_data  (ref_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign REF_READY_O = !fifo_full;
  assign DUT_READY_O = (state_q == ST_RUN) && !fifo_empty;
  assign dut_acc     = DUT_VALID_I && DUT_READY_O;
  assign PAUSE_REQ_O = (state_q == ST_PAUSED);
  assign OVERRUN_O   = (state_q == ST_ERROR);

  // One extra bit of headroom so extreme operands cannot wrap.
  assign diff        = {DUT_DATA_I[DATA_W-1], DUT_DATA_I} - {ref_data[DATA_W-1], ref_data};
  assign mm          = (diff > TOL) || (diff < -TOL);
  assign mm_cnt_next = mm ? sat_inc(MISMATCH_CNT_O) : MISMATCH_CNT_O;
  assign gmm_next    = mm ? sat_inc(gmm_q[DUT_CH_I]) : gmm_q[DUT_CH_I];
  assign at_end      = (pos_q[DUT_CH_I] == LAST_POS);
  assign framing_err = (DUT_LAST_I != at_end);

  always_ff @(posedge CLK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Pause decision uses the post-update count so PAUSE_REQ_O rises together
  // with the registered compare result; a framing error takes priority.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (dut_acc) begin
          if (framing_err) begin
            state_d = ST_ERROR;
          end else if ((PAUSE_THRESH != 0) && (mm_cnt_next >= THRESH)) begin
            state_d = ST_PAUSED;
          end
        end
      end
      ST_PAUSED: begin
        if (PAUSE_ACK_I) begin
          state_d = ST_RUN;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      MISMATCH_O     <= 1'b0;
      DIFF_O         <= '0;
      MISMATCH_CNT_O <= '0;
      GRANULE_DONE_O <= 1'b0;
      GRANULE_CH_O   <= '0;
      GRANULE_MM_O   <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        pos_q[CH_W'(i)] <= '0;
        gmm_q[CH_W'(i)] <= '0;
      end
    end else begin
      MISMATCH_O     <= 1'b0;
      GRANULE_DONE_O <= 1'b0;
      if (dut_acc) begin
        MISMATCH_O     <= mm;
        DIFF_O         <= diff;
        MISMATCH_CNT_O <= mm_cnt_next;
        GRANULE_MM_O   <= gmm_next;
        if (at_end) begin
          pos_q[DUT_CH_I] <= '0;
          gmm_q[DUT_CH_I] <= '0;
          GRANULE_DONE_O  <= 1'b1;
          GRANULE_CH_O    <= DUT_CH_I;
        end else begin
          pos_q[DUT_CH_I] <= pos_q[DUT_CH_I] + 1'b1;
          gmm_q[DUT_CH_I] <= gmm_next;
        end
      end else if ((state_q == ST_PAUSED) && PAUSE_ACK_I) begin
        MISMATCH_CNT_O <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sample_stream_checker.sv
module tb_sample_stream_checker;

  localparam int GLEN   = 576;
  localparam int TOL    = 1;
  localparam int THRESH = 4;
  localparam int DEPTH  = 8;
  localparam int TMO    = 200;

  logic        CLK_I = 1'b0;
  logic        RESETN_I = 1'b0;
  logic        REF_VALID_I = 1'b0;
  logic [15:0] REF_DATA_I = '0;
  logic        REF_READY_O;
  logic        DUT_VALID_I = 1'b0;
  logic [0:0]  DUT_CH_I = '0;
  logic [15:0] DUT_DATA_I = '0;
  logic        DUT_LAST_I = 1'b0;
  logic        DUT_READY_O;
  logic        PAUSE_ACK_I = 1'b0;
  logic        MISMATCH_O;
  logic signed [16:0] DIFF_O;
  logic [15:0] MISMATCH_CNT_O;
  logic        GRANULE_DONE_O;
  logic [0:0]  GRANULE_CH_O;
  logic [15:0] GRANULE_MM_O;
  logic        PAUSE_REQ_O;
  logic        OVERRUN_O;

  sample_stream_checker #(
    .DATA_W       (16),
    .CHANNELS     (2),
    .GRANULE_LEN  (GLEN),
    .TOLERANCE    (TOL),
    .PAUSE_THRESH (THRESH),
    .REF_DEPTH    (DEPTH)
  ) dut (
    .CLK_I          (CLK_I),
    .RESETN_I       (RESETN_I),
    .REF_VALID_I    (REF_VALID_I),
    .REF_DATA_I     (REF_DATA_I),
    .REF_READY_O    (REF_READY_O),
    .DUT_VALID_I    (DUT_VALID_I),
    .DUT_CH_I       (DUT_CH_I),
    .DUT_DATA_I     (DUT_DATA_I),
    .DUT_LAST_I     (DUT_LAST_I),
    .DUT_READY_O    (DUT_READY_O),
    .PAUSE_ACK_I    (PAUSE_ACK_I),
    .MISMATCH_O     (MISMATCH_O),
    .DIFF_O         (DIFF_O),
    .MISMATCH_CNT_O (MISMATCH_CNT_O),
    .GRANULE_DONE_O (GRANULE_DONE_O),
    .GRANULE_CH_O   (GRANULE_CH_O),
    .GRANULE_MM_O   (GRANULE_MM_O),
    .PAUSE_REQ_O    (PAUSE_REQ_O),
    .OVERRUN_O      (OVERRUN_O)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct {
    bit mm;
    int diff;
    int cnt;
    int gmm;
    bit gdone;
    int gch;
    bit pause;
    bit ovr;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] ref_q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model state: sample position and mismatches per channel,
  // running mismatch count, pause / error flags.
  int gcnt[2];
  int gmm[2];
  int run_cnt = 0;
  bit paused = 0;
  bit err = 0;

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d, required %0d", name, act, req);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic abort(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual no handshake, required one within %0d cycles", name, TMO);
    finish_sim();
  endtask

  task automatic settle();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic model_reset();
    ref_q.delete();
    exp_q.delete();
    for (int c = 0; c < 2; c++) begin
      gcnt[c] = 0;
      gmm[c]  = 0;
    end
    run_cnt = 0;
    paused  = 0;
    err     = 0;
  endtask

  task automatic push_ref(input logic [15:0] r);
    int n;
    REF_VALID_I = 1'b1;
    REF_DATA_I  = r;
    n = 0;
    forever begin
      @(negedge CLK_I);
      if (REF_READY_O) break;
      n++;
      if (n >= TMO) abort("ref_push_timeout");
    end
    @(posedge CLK_I);
    #1;
    REF_VALID_I = 1'b0;
    ref_q.push_back(r);
  endtask

  // Issues one DUT sample; LAST follows the model's framing unless 'bad'.
  task automatic send_dut(input int ch, input logic [15:0] d, input bit bad);
    exp_t        e;
    logic [15:0] r;
    bit          last_ok;
    int          n;
    last_ok     = (gcnt[ch] == GLEN - 1);
    DUT_VALID_I = 1'b1;
    DUT_CH_I    = 1'(ch);
    DUT_DATA_I  = d;
    DUT_LAST_I  = last_ok ^ bad;
    n = 0;
    forever begin
      @(negedge CLK_I);
      if (DUT_READY_O) break;
      n++;
      if (n >= TMO) abort("dut_handshake_timeout");
    end
    r = ref_q.pop_front();
    e.diff = int'($signed(d)) - int'($signed(r));
    e.mm   = (e.diff > TOL) || (e.diff < -TOL);
    if (e.mm) begin
      run_cnt = sat16(run_cnt);
      gmm[ch] = sat16(gmm[ch]);
    end
    if (bad) err = 1;
    e.gdone = last_ok;
    e.gch   = ch;
    e.gmm   = gmm[ch];
    if (last_ok) begin
      gcnt[ch] = 0;
      gmm[ch]  = 0;
    end else begin
      gcnt[ch]++;
    end
    if (!err && THRESH != 0 && run_cnt >= THRESH) paused = 1;
    e.cnt   = run_cnt;
    e.pause = paused;
    e.ovr   = err;
    exp_q.push_back(e);
    @(posedge CLK_I);
    #1;
    DUT_VALID_I = 1'b0;
    DUT_LAST_I  = 1'b0;
    if (paused) begin
      @(negedge CLK_I);
      chk("pause_req_on_thresh", PAUSE_REQ_O, 1);
      chk("pause_blocks_dut", DUT_READY_O, 0);
      settle();
      PAUSE_ACK_I = 1'b1;
      settle();
      PAUSE_ACK_I = 1'b0;
      run_cnt = 0;
      paused  = 0;
      @(negedge CLK_I);
      chk("ack_clears_cnt", MISMATCH_CNT_O, 0);
      chk("ack_resumes_run", PAUSE_REQ_O, 0);
      settle();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mismatch"}, MISMATCH_O, 0);
    chk({tag, "_diff"}, int'(DIFF_O), 0);
    chk({tag, "_mm_cnt"}, MISMATCH_CNT_O, 0);
    chk({tag, "_gdone"}, GRANULE_DONE_O, 0);
    chk({tag, "_gch"}, GRANULE_CH_O, 0);
    chk({tag, "_gmm"}, GRANULE_MM_O, 0);
    chk({tag, "_pause"}, PAUSE_REQ_O, 0);
    chk({tag, "_overrun"}, OVERRUN_O, 0);
    chk({tag, "_dut_ready"}, DUT_READY_O, 0);
  endtask

  // Monitor: outputs registered from a handshake are compared on the
  // following falling edge against the oldest expected entry.
  initial begin : monitor
    bit   acc_seen;
    exp_t e;
    acc_seen = 0;
    forever begin
      @(negedge CLK_I);
      if (!RESETN_I) begin
        acc_seen = 0;
      end else begin
        if (acc_seen) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_accept: actual handshake, required none");
          end else begin
            e = exp_q.pop_front();
            chk("mismatch_pulse", MISMATCH_O, e.mm);
            chk("diff", int'(DIFF_O), e.diff);
            chk("mismatch_cnt", MISMATCH_CNT_O, e.cnt);
            chk("granule_done", GRANULE_DONE_O, e.gdone);
            if (e.gdone) begin
              chk("granule_ch", GRANULE_CH_O, e.gch);
              chk("granule_mm", GRANULE_MM_O, e.gmm);
            end
            chk("pause_req", PAUSE_REQ_O, e.pause);
            chk("overrun", OVERRUN_O, e.ovr);
          end
        end else begin
          chk("mismatch_idle", MISMATCH_O, 0);
          chk("granule_done_idle", GRANULE_DONE_O, 0);
        end
        acc_seen = DUT_VALID_I && DUT_READY_O;
      end
    end
  end

  initial begin : stimulus
    logic [15:0] r;
    int          k;
    int          j;
    int          ch;
    int          off;
    model_reset();

    // Reset state
    @(negedge CLK_I);
    check_reset_outputs("reset");
    settle();
    RESETN_I = 1'b1;
    @(negedge CLK_I);
    chk("reset_ref_ready", REF_READY_O, 1);
    chk("reset_empty_stall", DUT_READY_O, 0);
    settle();

    // Exact ch0 granule
    for (int i = 0; i < GLEN; i++) begin
      r = 16'($urandom);
      push_ref(r);
      send_dut(0, r, 0);
    end

    // Tolerance window and extremes on ch1
    push_ref(16'd100); send_dut(1, 16'd101, 0);
    push_ref(16'd100); send_dut(1, 16'd99, 0);
    push_ref(16'd100); send_dut(1, 16'd102, 0);
    push_ref(16'd100); send_dut(1, 16'd97, 0);
    push_ref(16'h7FFF); send_dut(1, 16'h8000, 0);

    // Fourth mismatch with a reference still buffered; then finish ch1 granule
    push_ref(16'd0);
    push_ref(16'd0);
    send_dut(1, 16'd10, 0);
    send_dut(1, 16'd0, 0);
    while (gcnt[1] != 0) begin
      r = 16'($urandom);
      push_ref(r);
      send_dut(1, r, 0);
    end

    // Stall on empty, fill to full, simultaneous push/pop at depth 7
    DUT_VALID_I = 1'b1;
    DUT_DATA_I  = 16'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK_I);
      chk("empty_stall", DUT_READY_O, 0);
    end
    settle();
    DUT_VALID_I = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_ref(16'($urandom));
    @(negedge CLK_I);
    chk("full_ref_ready", REF_READY_O, 0);
    chk("full_dut_ready", DUT_READY_O, 1);
    settle();
    send_dut(0, ref_q[0], 0);
    chk("depth7_ref_ready", REF_READY_O, 1);
    r = 16'($urandom);
    REF_VALID_I = 1'b1;
    REF_DATA_I  = r;
    send_dut(0, ref_q[0], 0);
    REF_VALID_I = 1'b0;
    ref_q.push_back(r);
    for (int i = 0; i < 7; i++) send_dut(0, ref_q[0], 0);
    @(negedge CLK_I);
    chk("depth7_drained_empty", DUT_READY_O, 0);
    settle();

    // Randomised bursts, interleaved channels, occasional large errors
    for (int b = 0; b < 400; b++) begin
      k = $urandom_range(DEPTH - ref_q.size(), 1);
      for (int i = 0; i < k; i++) push_ref(16'($urandom));
      j = $urandom_range(ref_q.size(), 1);
      for (int i = 0; i < j; i++) begin
        ch = $urandom_range(1, 0);
        if ($urandom_range(15, 0) < 2) begin
          send_dut(ch, 16'($urandom), 0);
        end else begin
          off = int'($urandom_range(2, 0)) - 1;
          send_dut(ch, 16'(int'(ref_q[0]) + off), 0);
        end
      end
    end
    while (ref_q.size() != 0) send_dut(0, ref_q[0], 0);

    // Mid-granule reset: ch1 deep into a granule, one reference left buffered
    while (gcnt[1] != 480) begin
      r = 16'($urandom);
      push_ref(r);
      send_dut(1, r, 0);
    end
    push_ref(16'd0);
    send_dut(1, 16'd50, 0);
    push_ref(16'd7);
    repeat (3) settle();
    chk("pre_reset_dut_ready", DUT_READY_O, 1);
    chk("pre_reset_scoreboard_empty", exp_q.size(), 0);
    RESETN_I = 1'b0;
    @(negedge CLK_I);
    check_reset_outputs("midreset");
    model_reset();
    settle();
    settle();
    RESETN_I = 1'b1;
    @(negedge CLK_I);
    chk("post_reset_ref_ready", REF_READY_O, 1);
    chk("post_reset_fifo_discarded", DUT_READY_O, 0);
    settle();

    // Interleave restarts at position 0; misplaced LAST on ch1 sample 100
    for (int i = 0; i < 100; i++) begin
      r = 16'($urandom);
      push_ref(r);
      send_dut(0, r, 0);
      r = 16'($urandom);
      push_ref(r);
      send_dut(1, r, i == 99);
    end
    @(negedge CLK_I);
    chk("error_overrun", OVERRUN_O, 1);
    settle();
    push_ref(16'd5);
    @(negedge CLK_I);
    chk("error_blocks_dut", DUT_READY_O, 0);
    settle();
    PAUSE_ACK_I = 1'b1;
    settle();
    PAUSE_ACK_I = 1'b0;
    @(negedge CLK_I);
    chk("error_ack_ignored_overrun", OVERRUN_O, 1);
    chk("error_ack_ignored_ready", DUT_READY_O, 0);
    chk("error_ack_no_pause", PAUSE_REQ_O, 0);
    repeat (3) @(negedge CLK_I);
    chk("scoreboard_empty", exp_q.size(), 0);
    finish_sim();
  end

endmodule
